ppu_sprite_line_eval: RTL and testbench
=======================================

// Module: ppu_sprite_line_eval
// PURPOSE
// Per-scanline sprite evaluator/fetcher, next generation of the PPU line-fill logic; one pass per line_start.
// Scans OAM, selects the first MAX_PER_LINE sprites covering the line, then fetches each one's 32-bit graphics row.
// Drives the sprite line slots read by the pixel mux. OAM and sprite-graphics RAMs are read-only here.
// PARAMETERS
// NUM_SPRITES   128  OAM entries; entry n = word 2n {rot[31:30],rsv,pal[7],tile[6:0]}, word 2n+1 {y[31:16],x[15:0]}
// MAX_PER_LINE  4    sprite slots per line (1..16)
// SPRITE_H      16   rows per sprite; power of 2
// OAM_AW        8    OAM address width; must be >= clog2(2*NUM_SPRITES)
// GFX_AW        11   sprite graphics address width; gfx_addr = tile*SPRITE_H + row
// LINE_W        10   width of line input
// PORTS
// clk          in   1                 clock
// reset        in   1                 synchronous, active-high
// line_start   in   1                 1-cycle pulse: evaluate line `line`
// line         in   LINE_W            scanline number, sampled on accepted line_start
// oam_addr     out  OAM_AW            OAM read address (read-only access, 1-cycle latency)
// oam_rdata    in   32                OAM read data
// gfx_addr     out  GFX_AW            sprite graphics read address (1-cycle latency)
// gfx_rdata    in   32                16 px x 2bpp; px0 = bits[1:0]
// busy         out  1                 evaluation/fetch in progress
// done         out  1                 1-cycle pulse: slots valid for this line
// overflow     out  1                 >MAX_PER_LINE sprites hit this line
// slot_valid   out  MAX_PER_LINE      per-slot valid
// slot_x       out  16*MAX_PER_LINE   slot i at [16i+:16]
// slot_pal     out  MAX_PER_LINE      palette select bit
// slot_pixels  out  32*MAX_PER_LINE   fetched (flipped) graphics row
// BEHAVIOUR
// - Reset: all outputs 0; FSM -> IDLE; sprite count 0. Reset mid-pass aborts immediately; no done.
// - FSM: IDLE -> EVAL -> FETCH -> DONE -> IDLE.
// - IDLE: on line_start: latch line, clear slot_valid/overflow/count, busy=1, oam_addr=0, -> EVAL.
// - line_start while busy or in DONE: ignored; no state change.
// - EVAL: oam_addr increments each cycle 0..2*NUM_SPRITES-1; data arrives next cycle.
//   Even word: capture attrs. Odd word: row = {0,line} - y (16b); hit iff y <= line && row < SPRITE_H.
//   Hit with count < MAX_PER_LINE: write slot[count] x, pal, tile, row; count++.
//   Hit with count == MAX_PER_LINE: overflow=1, end EVAL at once.
//   After the last odd word is evaluated -> FETCH, or after overflow.
//   Max EVAL = 2*NUM_SPRITES+1 cycles. Lower OAM index wins slot priority.
// - FETCH: issue gfx_addr for slots 0..count-1, one per cycle.
//   slot_pixels[i] and slot_valid[i] are set the cycle data returns (count+1 cycles).
//   count==0: FETCH lasts 1 cycle, no gfx reads.
// - DONE: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
// - Slot outputs hold until the next accepted line_start.
// - gfx_addr arithmetic: tile(7b)*SPRITE_H + row, truncated to GFX_AW. Any y > line never hits (no wrap).
// CONFIGURATION
// PPU_SPRITE_FLIP_EN defined: rot[31]=vflip uses row' = SPRITE_H-1-row.
//   rot[30]=hflip reverses the order of the 16 2-bit pixels (px0<->px15); bit order within a pixel is kept.
// Undefined: rot bits ignored; row'=row, pixels unmodified.
// TESTING
// 1 Reset during EVAL -> next cycle busy=0, slot_valid=0, oam_addr=0; no done pulse.
// 2 Sprite 5 y=100 tile=3, line=107 -> slot0 x/pal correct, gfx_addr=3*16+7=55; done after 2*128+1+2 cycles.
// 3 Sprites 0..5 all y=50, line=50 -> slots = sprites 0..3, overflow=1, EVAL ends at sprite 4's coord word.
// 4 Boundaries, sprite y=200: line=199 miss, 200 hit row0, 215 hit row15, 216 miss; y=0xFFFF never hits.
// 5 FLIP_EN, vflip, line=y+2 -> row'=13; hflip, gfx_rdata=0x0000_0001 -> slot_pixels=0x4000_0000.
//   Without FLIP_EN: row=2, pixels unchanged.
// 6 line_start re-pulsed while busy -> ignored, result for first line; no sprites hit -> done, slot_valid=0.

Source files
------------

// File: rtl/ppu_sprite_line_eval_if.sv
// Read-only memory buses used by the sprite line evaluator: OAM words and sprite graphics rows.
// Both memories answer one cycle after the address is presented.
interface ppu_sprite_line_eval_if #(
   parameter int unsigned OAM_AW = 8,
   parameter int unsigned GFX_AW = 11
) ();
   logic [OAM_AW-1:0] oam_addr;
   logic [31:0]       oam_rdata;
   logic [GFX_AW-1:0] gfx_addr;
   logic [31:0]       gfx_rdata;

   modport master (
      output oam_addr,
      input  oam_rdata,
      output gfx_addr,
      input  gfx_rdata
   );

   modport slave (
      input  oam_addr,
      output oam_rdata,
      input  gfx_addr,
      output gfx_rdata
   );
endinterface

// File: rtl/ppu_sprite_line_eval.sv
// Per-scanline sprite evaluator: scans OAM for sprites covering the line, then fetches their rows.
// Define PPU_SPRITE_FLIP_EN to honour the OAM rot bits (rot[31]=vflip, rot[30]=hflip).
module ppu_sprite_line_eval #(
   parameter int unsigned NUM_SPRITES  = 128,
   parameter int unsigned MAX_PER_LINE = 4,
   parameter int unsigned SPRITE_H     = 16,
   parameter int unsigned OAM_AW       = 8,
   parameter int unsigned GFX_AW       = 11,
   parameter int unsigned LINE_W       = 10
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        line_start_i,
   input  logic [LINE_W-1:0]           line_i,
   ppu_sprite_line_eval_if.master      mem_if,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        overflow_o,
   output logic [MAX_PER_LINE-1:0]     slot_valid_o,
   output logic [16*MAX_PER_LINE-1:0]  slot_x_o,
   output logic [MAX_PER_LINE-1:0]     slot_pal_o,
   output logic [32*MAX_PER_LINE-1:0]  slot_pixels_o
);

   localparam int unsigned RowW     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int unsigned CntW     = $clog2(MAX_PER_LINE + 1);
   localparam int unsigned LastAddr = 2 * NUM_SPRITES - 1;

   typedef enum logic [1:0] {StIdle, StEval, StFetch, StDone} state_e;

   state_e                               state_q, state_d;
   logic [LINE_W-1:0]                    line_q, line_d;
   logic [OAM_AW-1:0]                    oam_addr_q, oam_addr_d;
   logic [OAM_AW-1:0]                    rd_addr_q, rd_addr_d;
   logic                                 rd_vld_q, rd_vld_d;
   logic [6:0]                           cap_tile_q, cap_tile_d;
   logic                                 cap_pal_q, cap_pal_d;
   logic [CntW-1:0]                      cnt_q, cnt_d;
   logic [CntW-1:0]                      fidx_q, fidx_d;
   logic                                 ovf_q, ovf_d;
   logic [MAX_PER_LINE-1:0]              valid_q, valid_d;
   logic [MAX_PER_LINE-1:0]              pal_q, pal_d;
   logic [MAX_PER_LINE-1:0][15:0]        x_q, x_d;
   logic [MAX_PER_LINE-1:0][6:0]         tile_q, tile_d;
   logic [MAX_PER_LINE-1:0][RowW-1:0]    row_q, row_d;
   logic [MAX_PER_LINE-1:0][31:0]        pix_q, pix_d;

   logic [15:0]     spr_y, line16, row_diff;
   logic            hit;
   logic [RowW-1:0] row_eff;

`ifdef PPU_SPRITE_FLIP_EN
   logic [1:0]              cap_rot_q, cap_rot_d;
   logic [MAX_PER_LINE-1:0] hflip_q, hflip_d;

   function automatic logic [31:0] px_reverse(input logic [31:0] d);
      logic [31:0] r;
      for (int k = 0; k < 16; k++) begin
         r[2*k +: 2] = d[2*(15-k) +: 2];
      end
      return r;
   endfunction
`endif

   // Y is compared unsigned against the zero-extended line, so sprites never wrap from the top.
   assign spr_y    = mem_if.oam_rdata[31:16];
   assign line16   = 16'(line_q);
   assign row_diff = line16 - spr_y;
   assign hit      = (spr_y <= line16) && (row_diff < 16'(SPRITE_H));

`ifdef PPU_SPRITE_FLIP_EN
   assign row_eff = cap_rot_q[1] ? (RowW'(SPRITE_H - 1) - RowW'(row_diff)) : RowW'(row_diff);
`else
   assign row_eff = RowW'(row_diff);
`endif

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      oam_addr_d = oam_addr_q;
      rd_addr_d  = oam_addr_q;
      rd_vld_d   = 1'b0;
      cap_tile_d = cap_tile_q;
      cap_pal_d  = cap_pal_q;
      cnt_d      = cnt_q;
      fidx_d     = fidx_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      pal_d      = pal_q;
      x_d        = x_q;
      tile_d     = tile_q;
      row_d      = row_q;
      pix_d      = pix_q;
`ifdef PPU_SPRITE_FLIP_EN
      cap_rot_d  = cap_rot_q;
      hflip_d    = hflip_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (line_start_i) begin
               state_d    = StEval;
               line_d     = line_i;
               valid_d    = '0;
               ovf_d      = 1'b0;
               cnt_d      = '0;
               oam_addr_d = '0;
            end
         end
         StEval: begin
            rd_vld_d = 1'b1;
            if (oam_addr_q != OAM_AW'(LastAddr)) begin
               oam_addr_d = oam_addr_q + 1'b1;
            end
            if (rd_vld_q) begin
               if (!rd_addr_q[0]) begin
                  cap_tile_d = mem_if.oam_rdata[6:0];
                  cap_pal_d  = mem_if.oam_rdata[7];
`ifdef PPU_SPRITE_FLIP_EN
                  cap_rot_d  = mem_if.oam_rdata[31:30];
`endif
               end else begin
                  if (hit && (cnt_q == CntW'(MAX_PER_LINE))) begin
                     ovf_d   = 1'b1;
                     state_d = StFetch;
                  end else if (hit) begin
                     for (int i = 0; i < MAX_PER_LINE; i++) begin
                        if (CntW'(i) == cnt_q) begin
                           x_d[i]    = mem_if.oam_rdata[15:0];
                           pal_d[i]  = cap_pal_q;
                           tile_d[i] = cap_tile_q;
                           row_d[i]  = row_eff;
`ifdef PPU_SPRITE_FLIP_EN
                           hflip_d[i] = cap_rot_q[0];
`endif
                        end
                     end
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (rd_addr_q == OAM_AW'(LastAddr)) begin
                     state_d = StFetch;
                  end
               end
            end
            if (state_d == StFetch) begin
               rd_vld_d   = 1'b0;
               oam_addr_d = oam_addr_q;
               fidx_d     = '0;
            end
         end
         StFetch: begin
            // Data on gfx_rdata belongs to the slot addressed in the previous cycle.
            for (int i = 0; i < MAX_PER_LINE; i++) begin
               if (fidx_q == CntW'(i + 1)) begin
`ifdef PPU_SPRITE_FLIP_EN
                  pix_d[i] = hflip_q[i] ? px_reverse(mem_if.gfx_rdata) : mem_if.gfx_rdata;
`else
                  pix_d[i] = mem_if.gfx_rdata;
`endif
                  valid_d[i] = 1'b1;
               end
            end
            if (fidx_q == cnt_q) begin
               state_d = StDone;
            end else begin
               fidx_d = fidx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_if.gfx_addr = '0;
      if ((state_q == StFetch) && (fidx_q < cnt_q)) begin
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (CntW'(i) == fidx_q) begin
               mem_if.gfx_addr = GFX_AW'(32'(tile_q[i]) * 32'(SPRITE_H) + 32'(row_q[i]));
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         line_q     <= '0;
         oam_addr_q <= '0;
         rd_addr_q  <= '0;
         rd_vld_q   <= 1'b0;
         cap_tile_q <= '0;
         cap_pal_q  <= 1'b0;
         cnt_q      <= '0;
         fidx_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= '0;
         pal_q      <= '0;
         x_q        <= '0;
         tile_q     <= '0;
         row_q      <= '0;
         pix_q      <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         oam_addr_q <= oam_addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_vld_q   <= rd_vld_d;
         cap_tile_q <= cap_tile_d;
         cap_pal_q  <= cap_pal_d;
         cnt_q      <= cnt_d;
         fidx_q     <= fidx_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         pal_q      <= pal_d;
         x_q        <= x_d;
         tile_q     <= tile_d;
         row_q      <= row_d;
         pix_q      <= pix_d;
      end
   end

`ifdef PPU_SPRITE_FLIP_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cap_rot_q <= '0;
         hflip_q   <= '0;
      end else begin
         cap_rot_q <= cap_rot_d;
         hflip_q   <= hflip_d;
      end
   end
`endif

   assign mem_if.oam_addr = oam_addr_q;
   assign busy_o          = (state_q == StEval) || (state_q == StFetch);
   assign done_o          = (state_q == StDone);
   assign overflow_o      = ovf_q;
   assign slot_valid_o    = valid_q;
   assign slot_x_o        = x_q;
   assign slot_pal_o      = pal_q;
   assign slot_pixels_o   = pix_q;

endmodule

// File: tb/tb_ppu_sprite_line_eval.sv
// Bench for ppu_sprite_line_eval: directed and random scanlines against a sprite-list model.
// Build with PPU_SPRITE_FLIP_EN defined to exercise the flip path; the model follows the same macro.
module tb_ppu_sprite_line_eval;
   localparam int NS = 128, MAXS = 4, SH = 16, OA = 8, GA = 11, LW = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic line_start = 1'b0;
   logic [LW-1:0] line = '0;
   logic busy, done, overflow;
   logic [MAXS-1:0] slot_valid, slot_pal;
   logic [16*MAXS-1:0] slot_x;
   logic [32*MAXS-1:0] slot_pixels;

   logic [31:0] oam_mem [2*NS];
   logic [31:0] gfx_mem [1<<GA];

   int checks = 0;
   int errors = 0;
   int last_lat;
   logic exp_ovf;
   logic [MAXS-1:0] exp_valid;
   logic [15:0] exp_x [MAXS];
   logic exp_pal [MAXS];
   logic [31:0] exp_pix [MAXS];
   int exp_lat;

   ppu_sprite_line_eval_if #(.OAM_AW(OA), .GFX_AW(GA)) mem_if ();

   ppu_sprite_line_eval #(
      .NUM_SPRITES(NS), .MAX_PER_LINE(MAXS), .SPRITE_H(SH),
      .OAM_AW(OA), .GFX_AW(GA), .LINE_W(LW)
   ) dut (
      .clk_i(clk), .reset_i(reset), .line_start_i(line_start), .line_i(line),
      .mem_if(mem_if), .busy_o(busy), .done_o(done), .overflow_o(overflow),
      .slot_valid_o(slot_valid), .slot_x_o(slot_x), .slot_pal_o(slot_pal),
      .slot_pixels_o(slot_pixels)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_if.oam_rdata <= oam_mem[mem_if.oam_addr];
      mem_if.gfx_rdata <= gfx_mem[mem_if.gfx_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic set_sprite(input int n, input int y, input int x, input int tile,
                             input int pal, input int rot);
      oam_mem[2*n]   = {2'(rot), 22'($urandom), 1'(pal), 7'(tile)};
      oam_mem[2*n+1] = {16'(y), 16'(x)};
   endtask

   task automatic clear_oam();
      for (int s = 0; s < NS; s++) set_sprite(s, 'hFFFF, $urandom, $urandom, $urandom, $urandom);
   endtask

   // Walk sprites in OAM order; keep the first MAXS that cover the line.
   task automatic model(input int ln);
      int cnt = 0;
      int eval_cyc = 2*NS + 1;
      exp_ovf = 1'b0;
      exp_valid = '0;
      for (int s = 0; s < NS; s++) begin
         int y, row, tile;
         logic [1:0] rot;
         logic [31:0] px;
         y = int'(oam_mem[2*s+1][31:16]);
         if (ln >= y && ln - y < SH) begin
            if (cnt == MAXS) begin
               exp_ovf = 1'b1;
               eval_cyc = 2*s + 3;
               break;
            end
            row = ln - y;
            tile = int'(oam_mem[2*s][6:0]);
            rot = oam_mem[2*s][31:30];
`ifdef PPU_SPRITE_FLIP_EN
            if (rot[1]) row = SH - 1 - row;
`endif
            px = gfx_mem[(tile*SH + row) % (1<<GA)];
`ifdef PPU_SPRITE_FLIP_EN
            if (rot[0]) begin
               logic [31:0] r;
               for (int p = 0; p < 16; p++) r[2*p +: 2] = px[30-2*p +: 2];
               px = r;
            end
`endif
            exp_valid[cnt] = 1'b1;
            exp_x[cnt] = oam_mem[2*s+1][15:0];
            exp_pal[cnt] = oam_mem[2*s][7];
            exp_pix[cnt] = px;
            cnt++;
         end
      end
      exp_lat = eval_cyc + cnt + 1;
   endtask

   task automatic start_line(input int ln);
      @(negedge clk);
      line_start = 1'b1;
      line = LW'(ln);
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic run_line(input int ln, input string tag, input int ghost);
      int n = 0;
      model(ln);
      start_line(ln);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      while (done !== 1'b1 && n < 600) begin
         if (n == ghost) begin
            line_start = 1'b1;
            line = ~line;
         end else begin
            line_start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      line_start = 1'b0;
      last_lat = n;
      chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
      chk({tag, ".valid"}, 32'(slot_valid), 32'(exp_valid));
      for (int i = 0; i < MAXS; i++) begin
         if (exp_valid[i]) begin
            chk($sformatf("%s.x%0d", tag, i), 32'(slot_x[16*i +: 16]), 32'(exp_x[i]));
            chk($sformatf("%s.pal%0d", tag, i), 32'(slot_pal[i]), 32'(exp_pal[i]));
            chk($sformatf("%s.pix%0d", tag, i), slot_pixels[32*i +: 32], exp_pix[i]);
         end
      end
      // A start pulse during DONE must be dropped.
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({tag, ".ign_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int ndone;
      int t4_lines [4];
      logic [3:0] t4_hit;
      logic [31:0] expv;
      t4_lines = '{199, 200, 215, 216};
      t4_hit = 4'b0110;

      for (int a = 0; a < (1<<GA); a++) gfx_mem[a] = $urandom;
      clear_oam();

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      chk("rst.valid", 32'(slot_valid), 32'd0);
      chk("rst.nz_slots", 32'((slot_x != '0) || (slot_pixels != '0) || (slot_pal != '0)), 32'd0);
      chk("rst.oam_addr", 32'(mem_if.oam_addr), 32'd0);
      chk("rst.gfx_addr", 32'(mem_if.gfx_addr), 32'd0);
      reset = 1'b0;

      // Single sprite deep in OAM
      clear_oam();
      set_sprite(5, 100, 'h123, 3, 1, 0);
      run_line(107, "t2", -1);
      chk("t2.lat259", 32'(last_lat), 32'd259);
      chk("t2.pix55", slot_pixels[31:0], gfx_mem[55]);
      chk("t2.x", 32'(slot_x[15:0]), 32'h123);

      // Overflow: six sprites on one line
      clear_oam();
      for (int s = 0; s < 6; s++) set_sprite(s, 50, s*10, s+1, s%2, 0);
      run_line(50, "t3", -1);
      chk("t3.ovf", 32'(overflow), 32'd1);
      chk("t3.lat", 32'(last_lat), 32'd16);
      chk("t3.x3", 32'(slot_x[63:48]), 32'd30);

      // Reset during FETCH after some slots became valid
      start_line(50);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t3r.valid", 32'(slot_valid), 32'd0);
      chk("t3r.ovf", 32'(overflow), 32'd0);
      chk("t3r.busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Reset during EVAL
      clear_oam();
      set_sprite(0, 40, 9, 1, 0, 0);
      start_line(45);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t1.busy", 32'(busy), 32'd0);
      chk("t1.valid", 32'(slot_valid), 32'd0);
      chk("t1.oam_addr", 32'(mem_if.oam_addr), 32'd0);
      chk("t1.done", 32'(done), 32'd0);
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("t1.nodone", 32'(ndone), 32'd0);

      // Vertical boundaries of a sprite at y=200
      clear_oam();
      set_sprite(9, 200, 77, 12, 0, 0);
      for (int i = 0; i < 4; i++) begin
         run_line(t4_lines[i], $sformatf("t4_%0d", t4_lines[i]), -1);
         chk($sformatf("t4.hit%0d", t4_lines[i]), 32'(slot_valid[0]), 32'(t4_hit[i]));
      end
      set_sprite(9, 'hFFFF, 77, 12, 0, 0);
      run_line(1023, "t4_ffff", -1);

      // Flip handling
      clear_oam();
      set_sprite(2, 300, 5, 10, 1, 2);
      run_line(302, "t5v", -1);
`ifdef PPU_SPRITE_FLIP_EN
      expv = gfx_mem[173];
`else
      expv = gfx_mem[162];
`endif
      chk("t5v.row", slot_pixels[31:0], expv);
      set_sprite(2, 300, 5, 10, 1, 1);
      gfx_mem[162] = 32'h0000_0001;
      run_line(302, "t5h", -1);
`ifdef PPU_SPRITE_FLIP_EN
      expv = 32'h4000_0000;
`else
      expv = 32'h0000_0001;
`endif
      chk("t5h.pix", slot_pixels[31:0], expv);

      // Start pulse while busy is ignored; the ghost line would hit sprite 7
      clear_oam();
      set_sprite(7, 523, 1, 2, 1, 0);
      run_line(500, "t6", 5);
      chk("t6.lat", 32'(last_lat), 32'd258);
      chk("t6.valid", 32'(slot_valid), 32'd0);

      // Random OAM contents, alternating sparse and dense populations
      for (int it = 0; it < 8; it++) begin
         int ln;
         ln = $urandom_range(0, 1023);
         for (int s = 0; s < NS; s++) begin
            int y;
            if (it % 2 == 0) y = $urandom_range(0, 1100);
            else y = ln - 15 + $urandom_range(0, 200);
            if (y < 0) y = y + 65536;
            set_sprite(s, y, $urandom, $urandom, $urandom, $urandom);
         end
         run_line(ln, $sformatf("rnd%0d", it), (it == 3) ? 7 : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
